sr_flip_flop: RTL and testbench



---
 rtl/sr_pkg.sv | 31 +++
 rtl/sr_cell.sv | 36 +++
 rtl/sr_flip_flop.sv | 56 +++++
 tb/tb_sr_flip_flop.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank.
//   SR_HOLD / SR_RST_DOM / SR_SET_DOM / SR_TOGGLE : encodings of the S=R=1 action
//   sr_next(q, s, r, mode)                        : next-state bit for one SR cell
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'd0;
  localparam logic [1:0] SR_RST_DOM = 2'd1;
  localparam logic [1:0] SR_SET_DOM = 2'd2;
  localparam logic [1:0] SR_TOGGLE  = 2'd3;

  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input logic [1:0] mode);
    logic nxt;
    nxt = q;
    case ({s, r})
      2'b00:   nxt = q;
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      default: begin
        case (mode)
          SR_HOLD:    nxt = q;
          SR_RST_DOM: nxt = 1'b0;
          SR_SET_DOM: nxt = 1'b1;
          default:    nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// Single SR storage bit with asynchronous active-high reset.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; loads RESET_VALUE
//   s, r  : set / reset requests sampled on the rising edge
//   q     : stored bit
module sr_cell
  import sr_pkg::*;
#(
  parameter logic       RESET_VALUE = 1'b0,
  parameter logic [1:0] MODE        = SR_RST_DOM
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = sr_next(q_q, s, r, MODE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with complementary outputs.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; q <= RESET_VALUE
//   S, R  : per-bit set / reset requests
//   q     : stored state
//   qb    : ~q, derived from the same register so q and qb can never agree
// BOTH_MODE selects the S=R=1 action: 0 hold, 1 reset-dominant, 2 set-dominant, 3 toggle.
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter int unsigned           BOTH_MODE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  localparam logic [1:0] Mode = BOTH_MODE[1:0];

  if (BOTH_MODE > 3) begin : g_bad_mode
    $error("sr_flip_flop: BOTH_MODE must be 0..3");
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .RESET_VALUE(RESET_VALUE[i]),
      .MODE       (Mode)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .s    (S[i]),
      .r    (R[i]),
      .q    (q[i])
    );
  end

  assign qb = ~q;

`ifndef SYNTHESIS
  // X on the request inputs is unsupported; flag it wherever it would be sampled.
  a_s_known : assert property (@(posedge clk) disable iff (reset) !$isunknown(S))
    else $error("sr_flip_flop: X on S");
  a_r_known : assert property (@(posedge clk) disable iff (reset) !$isunknown(R))
    else $error("sr_flip_flop: X on R");
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
module tb_sr_flip_flop;

  logic       clk;
  logic       reset;
  logic [1:0] S;
  logic [1:0] R;
  logic [1:0] q0, q1, q2, q3;
  logic [1:0] qb0, qb1, qb2, qb3;

  logic       resetf;
  logic       sf;
  logic       rf;
  logic       qf;
  logic       qbf;

  typedef struct {
    string      name;
    bit         is_free;
    logic [7:0] exp_m;   // {mode3, mode2, mode1, mode0}, two bits each
    logic       exp_f;
  } exp_t;

  exp_t sb[$];
  event pushed;
  int   n_checks;
  int   n_fail;
  logic model_f;

  sr_flip_flop #(.WIDTH(2), .RESET_VALUE(2'b00), .BOTH_MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .S(S), .R(R), .q(q0), .qb(qb0));
  sr_flip_flop #(.WIDTH(2), .RESET_VALUE(2'b00), .BOTH_MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .S(S), .R(R), .q(q1), .qb(qb1));
  sr_flip_flop #(.WIDTH(2), .RESET_VALUE(2'b00), .BOTH_MODE(2)) u_m2 (
    .clk(clk), .reset(reset), .S(S), .R(R), .q(q2), .qb(qb2));
  sr_flip_flop #(.WIDTH(2), .RESET_VALUE(2'b00), .BOTH_MODE(3)) u_m3 (
    .clk(clk), .reset(reset), .S(S), .R(R), .q(q3), .qb(qb3));

  // Default parameters: WIDTH=1, RESET_VALUE=0, reset-dominant.
  sr_flip_flop u_free (
    .clk(clk), .reset(resetf), .S(sf), .R(rf), .q(qf), .qb(qbf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic push(input string name, input bit is_free, input logic [7:0] exp_m,
                      input logic exp_f);
    exp_t it;
    it.name    = name;
    it.is_free = is_free;
    it.exp_m   = exp_m;
    it.exp_f   = exp_f;
    sb.push_back(it);
    -> pushed;
  endtask

  task automatic step(input string name, input logic [1:0] s, input logic [1:0] r,
                      input logic [1:0] e0, input logic [1:0] e1,
                      input logic [1:0] e2, input logic [1:0] e3);
    @(negedge clk);
    S = s;
    R = r;
    @(posedge clk);
    #1;
    push(name, 1'b0, {e3, e2, e1, e0}, 1'b0);
  endtask

  // Monitor: drains the scoreboard and compares against the live outputs.
  initial begin
    exp_t        it;
    logic [7:0]  act_m;
    logic [7:0]  act_mb;
    forever begin
      @(pushed);
      while (sb.size() != 0) begin
        it = sb.pop_front();
        n_checks++;
        if (it.is_free) begin
          if (qf !== it.exp_f || qbf !== ~it.exp_f) begin
            n_fail++;
            $display("FAIL %s @%0t: q=%b qb=%b, expected q=%b qb=%b",
                     it.name, $time, qf, qbf, it.exp_f, ~it.exp_f);
          end
        end else begin
          act_m  = {q3, q2, q1, q0};
          act_mb = {qb3, qb2, qb1, qb0};
          if (act_m !== it.exp_m || act_mb !== ~it.exp_m) begin
            n_fail++;
            $display("FAIL %s @%0t: q[m3..m0]=%b qb=%b, expected q=%b qb=%b",
                     it.name, $time, act_m, act_mb, it.exp_m, ~it.exp_m);
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    resetf   = 1'b0;
    S        = 2'b00;
    R        = 2'b00;
    sf       = 1'b0;
    rf       = 1'b0;
    model_f  = 1'b0;

    // Reset asserted between clock edges must clear outputs immediately.
    #1;
    reset  = 1'b1;
    resetf = 1'b1;
    #1;
    push("rst_immediate", 1'b0, 8'h00, 1'b0);

    // Hold reset for 40 ns while S/R toggle; outputs must stay cleared.
    for (int i = 0; i < 8; i++) begin
      #5;
      S = ~S;
      if (i % 2 == 1) R = ~R;
      push("rst_hold", 1'b0, 8'h00, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    S     = 2'b00;
    R     = 2'b00;

    step("set",        2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
    step("hold_a",     2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
    step("hold_b",     2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
    step("hold_c",     2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);
    step("clear",      2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10);
    step("clear_hold", 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10);
    step("set_both",   2'b01, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11);
    step("both_1",     2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10);
    step("both_2",     2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11);
    step("both_bit1",  2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b00);
    step("both_from0", 2'b11, 2'b11, 2'b10, 2'b00, 2'b11, 2'b11);
    step("set_all",    2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11);

    // Asynchronous reset 3 ns after an edge.
    @(posedge clk);
    #3;
    reset = 1'b1;
    S     = 2'b00;
    R     = 2'b00;
    #1;
    push("async_rst", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_set", 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01);

    // Reset raised in the same timestep as a set edge: reset wins.
    @(negedge clk);
    S = 2'b11;
    R = 2'b00;
    @(posedge clk);
    reset = 1'b1;
    #1;
    push("rst_at_edge", 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    S     = 2'b00;
    R     = 2'b00;

    // Free-running: S every 10 ns, R every 20 ns, reset every 40 ns.
    @(negedge clk);
    resetf  = 1'b0;
    model_f = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      sf = ~sf;
      if (k % 2 == 0) rf = ~rf;
      if (k % 4 == 0) begin
        resetf = ~resetf;
        if (resetf) begin
          #1;
          push("free_async", 1'b1, 8'h00, 1'b0);
        end
      end
      @(posedge clk);
      if (resetf)           model_f = 1'b0;
      else if (sf && !rf)   model_f = 1'b1;
      else if (!sf && rf)   model_f = 1'b0;
      else if (sf && rf)    model_f = 1'b0;
      #1;
      push("free", 1'b1, 8'h00, model_f);
    end

    #20;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
